// File: rtl/qpp_interleaver_stream_pkg.sv
// Shared constants for the streaming QPP interleaver: sizes, ksel codes,
// per-size generator table and the mod-K adder used by the address generator.
package qpp_interleaver_stream_pkg;

  localparam int KMAX = 6144;
  localparam int AW   = 13;

  localparam logic [1:0] KSEL_40   = 2'd0;
  localparam logic [1:0] KSEL_1056 = 2'd1;
  localparam logic [1:0] KSEL_6144 = 2'd2;
  localparam logic [1:0] KSEL_RSVD = 2'd3;

  typedef logic [AW-1:0] addr_t;

  // g0 = (f1+f2) mod K, d = 2*f2 mod K
  typedef struct packed {
    addr_t k;
    addr_t g0;
    addr_t d;
  } qpp_cfg_t;

  function automatic qpp_cfg_t qpp_cfg(input logic [1:0] ksel);
    qpp_cfg_t c;
    case (ksel)
      KSEL_1056: c = '{k: AW'(1056), g0: AW'(83),  d: AW'(132)};
      KSEL_6144: c = '{k: AW'(6144), g0: AW'(743), d: AW'(960)};
      default:   c = '{k: AW'(40),   g0: AW'(13),  d: AW'(20)};
    endcase
    return c;
  endfunction

  function automatic addr_t mod_add(input addr_t a, input addr_t b, input addr_t k);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[AW-1:0];
  endfunction

endpackage

// File: rtl/qpp_interleaver_stream_addr_gen.sv
// Incremental QPP address generator: pi(i+1)=pi(i)+g(i), g(i+1)=g(i)+2*f2, all mod K.
// Stepping at idx=K-1 rewinds to i=0 so pi is never advanced past the block.
module qpp_addr_gen
  import qpp_interleaver_stream_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic [1:0] ksel_i,
  output addr_t      pi_o,
  output addr_t      idx_o,
  output logic       last_o
);

  qpp_cfg_t cfg;
  addr_t    pi_q, pi_d, g_q, g_d, idx_q, idx_d;

  assign cfg    = qpp_cfg(ksel_i);
  assign last_o = (idx_q == cfg.k - AW'(1));
  assign pi_o   = pi_q;
  assign idx_o  = idx_q;

  always_comb begin
    pi_d  = pi_q;
    g_d   = g_q;
    idx_d = idx_q;
    if (clr_i || (step_i && last_o)) begin
      pi_d  = '0;
      g_d   = cfg.g0;
      idx_d = '0;
    end else if (step_i) begin
      pi_d  = mod_add(pi_q, g_q, cfg.k);
      g_d   = mod_add(g_q, cfg.d, cfg.k);
      idx_d = idx_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pi_q  <= '0;
      g_q   <= '0;
      idx_q <= '0;
    end else begin
      pi_q  <= pi_d;
      g_q   <= g_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/qpp_interleaver_stream.sv
// Streaming QPP interleaver/deinterleaver: load K bits into a buffer, then
// emit them permuted through a 2-entry skid buffer with credit-based reads.
module qpp_interleaver_stream
  import qpp_interleaver_stream_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] ksel_i,
  input  logic       deint_i,
  input  logic       in_bit_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       out_bit_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       cfg_err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] ksel_q;
  logic       deint_q;
  logic       cfg_err_q;
  logic       rd_done_q, rd_vld_q, rd_last_q, rdata_q;
  logic [1:0] sk_bit_q, sk_last_q, sk_cnt_q;
  logic       sk_head_q;

  logic       go, wr_en, rd_en, pop, push, wslot;
  logic [2:0] occ;
  logic [1:0] gen_ksel;
  addr_t      gen_pi, gen_idx, wa, ra;
  logic       gen_last;

  logic mem [KMAX];

  assign go    = (state_q == S_IDLE) && start_i && (ksel_i != KSEL_RSVD);
  assign wr_en = (state_q == S_LOAD) && in_valid_i;
  assign pop   = out_valid_o && out_ready_i;
  assign push  = rd_vld_q;
  // Entries held plus the read still in flight, net of this cycle's pop.
  assign occ   = 3'(sk_cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign rd_en = (state_q == S_UNLOAD) && !rd_done_q && (occ < 3'd2);
  assign wslot = sk_head_q ^ sk_cnt_q[0];

  // Before the latch happens the generator must already see the new size.
  assign gen_ksel = (state_q == S_IDLE) ? ksel_i : ksel_q;
  assign wa       = deint_q ? gen_pi  : gen_idx;
  assign ra       = deint_q ? gen_idx : gen_pi;

  qpp_addr_gen u_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (go || (wr_en && gen_last)),
    .step_i  (wr_en || rd_en),
    .ksel_i  (gen_ksel),
    .pi_o    (gen_pi),
    .idx_o   (gen_idx),
    .last_o  (gen_last)
  );

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wa] <= in_bit_i;
    if (rd_en) rdata_q <= mem[ra];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = S_LOAD;
      S_LOAD:   if (wr_en && gen_last) state_d = S_UNLOAD;
      S_UNLOAD: if (pop && out_last_o) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      ksel_q    <= KSEL_40;
      deint_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      sk_bit_q  <= '0;
      sk_last_q <= '0;
      sk_cnt_q  <= '0;
      sk_head_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= (state_q == S_IDLE) && start_i && (ksel_i == KSEL_RSVD);
      if (go) begin
        ksel_q  <= ksel_i;
        deint_q <= deint_i;
      end
      if (go)                     rd_done_q <= 1'b0;
      else if (rd_en && gen_last) rd_done_q <= 1'b1;
      rd_vld_q  <= rd_en;
      rd_last_q <= rd_en && gen_last;
      if (push) begin
        sk_bit_q[wslot]  <= rdata_q;
        sk_last_q[wslot] <= rd_last_q;
      end
      if (pop) sk_head_q <= ~sk_head_q;
      sk_cnt_q <= sk_cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (sk_cnt_q != 2'd0);
  assign out_bit_o   = sk_bit_q[sk_head_q];
  assign out_last_o  = out_valid_o && sk_last_q[sk_head_q];
  assign busy_o      = (state_q != S_IDLE);
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_qpp_interleaver_stream.sv
// Scoreboard bench: expected bits from a direct pi(i)=(f1*i+f2*i^2) mod K model
// are queued at stimulus time; a negedge monitor pops and compares on each handshake.
module tb_qpp_interleaver_stream;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [1:0] ksel_i = 2'd0;
  logic       deint_i = 1'b0;
  logic       in_bit_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o, out_bit_o, out_valid_o, out_last_o, busy_o, cfg_err_o;
  logic       out_ready_i = 1'b1;

  qpp_interleaver_stream dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .ksel_i(ksel_i),
    .deint_i(deint_i), .in_bit_i(in_bit_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_bit_o(out_bit_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic b; logic l; } exp_t;
  exp_t exp_q[$];
  logic got[$];

  int KT [3] = '{40, 1056, 6144};
  int F1 [3] = '{3, 17, 263};
  int F2 [3] = '{10, 66, 480};

  logic in_vec  [6144];
  logic orig    [6144];
  logic save_in [6144];
  logic ref_out [6144];
  int   perm    [6144];

  int n_cmp = 0;
  int n_err = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: handshake comparison and stall-stability checks.
  initial begin
    logic prev_stall, prev_bit, prev_last;
    exp_t e;
    prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
    forever begin
      @(negedge clk_i);
      if (reset_i) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check("hold_valid", int'(out_valid_o), 1);
          check("hold_bit",   int'(out_bit_o),   int'(prev_bit));
          check("hold_last",  int'(out_last_o),  int'(prev_last));
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) fail_now("unexpected_output");
          else begin
            e = exp_q.pop_front();
            check("out_bit",  int'(out_bit_o),  int'(e.b));
            check("out_last", int'(out_last_o), int'(e.l));
          end
          got.push_back(out_bit_o);
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_bit   = out_bit_o;
        prev_last  = out_last_o;
      end
    end
  end

  initial forever begin
    @(posedge clk_i); #1;
    out_ready_i = rand_rdy ? 1'($urandom % 2) : 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic build_perm(input int s);
    for (int i = 0; i < KT[s]; i++)
      perm[i] = int'((longint'(F1[s]) * i + longint'(F2[s]) * i * i) % KT[s]);
  endtask

  task automatic push_expect(input int s, input bit di, input bit rt);
    logic tmp [6144];
    int k = KT[s];
    build_perm(s);
    for (int i = 0; i < k; i++) begin
      if (rt)       tmp[i] = orig[i];
      else if (!di) tmp[i] = in_vec[perm[i]];
      else          tmp[perm[i]] = in_vec[i];
    end
    for (int j = 0; j < k; j++) exp_q.push_back(exp_t'{tmp[j], logic'(j == k - 1)});
  endtask

  task automatic do_start(input int s, input bit di);
    int t = 0;
    while (busy_o && t < 50000) begin @(posedge clk_i); t++; end
    if (busy_o) fail_now("start_wait_timeout");
    @(posedge clk_i); #1;
    start_i = 1'b1; ksel_i = 2'(s); deint_i = di;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int k, input bit stall, input int poke);
    int  i = 0, t = 0;
    logic acc;
    while (i < k && t < 60000) begin
      in_valid_i = stall ? 1'($urandom % 2) : 1'b1;
      in_bit_i   = in_vec[i];
      if (i == poke) begin start_i = 1'b1; ksel_i = 2'd2; deint_i = 1'b1; end
      else start_i = 1'b0;
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      @(posedge clk_i); #1;
      if (acc) i++;
      t++;
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    if (i < k) fail_now("feed_timeout");
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 60000) begin @(posedge clk_i); t++; end
    if (exp_q.size() != 0 || busy_o) fail_now("drain_timeout");
  endtask

  task automatic run_block(input int s, input bit di, input bit stall, input bit rt, input int poke);
    got.delete();
    push_expect(s, di, rt);
    do_start(s, di);
    feed(KT[s], stall, poke);
    wait_drain();
  endtask

  task automatic rand_vec(input int k);
    for (int i = 0; i < k; i++) in_vec[i] = 1'($urandom % 2);
  endtask

  initial begin
    int ones, cnt_err, cnt_busy, t;

    // Reset state
    #12;
    check("rst_in_ready",  int'(in_ready_o),  0);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_out_bit",   int'(out_bit_o),   0);
    check("rst_out_last",  int'(out_last_o),  0);
    check("rst_busy",      int'(busy_o),      0);
    check("rst_cfg_err",   int'(cfg_err_o),   0);
    @(posedge clk_i); #1; reset_i = 1'b0;

    // K40 one-hot checks
    for (int i = 0; i < 40; i++) in_vec[i] = 1'b0;
    in_vec[13] = 1'b1;
    run_block(0, 1'b0, 1'b0, 1'b0, -1);
    check("k40_onehot13_len", got.size(), 40);
    ones = 0;
    foreach (got[j]) ones += int'(got[j]);
    check("k40_onehot13_ones", ones, 1);
    if (got.size() > 1) check("k40_onehot13_idx1", int'(got[1]), 1);
    for (int i = 0; i < 40; i++) in_vec[i] = 1'b0;
    in_vec[6] = 1'b1;
    run_block(0, 1'b0, 1'b0, 1'b0, -1);
    if (got.size() > 2) check("k40_onehot6_idx2", int'(got[2]), 1);

    // Random interleave vs model, then round trip through deinterleave
    for (int s = 0; s < 3; s++) begin
      rand_vec(KT[s]);
      for (int i = 0; i < KT[s]; i++) orig[i] = in_vec[i];
      run_block(s, 1'b0, 1'b0, 1'b0, -1);
      check("rt_fwd_len", got.size(), KT[s]);
      if (s == 2) begin
        for (int i = 0; i < 6144; i++) begin
          save_in[i] = orig[i];
          ref_out[i] = (i < got.size()) ? got[i] : 1'b0;
        end
      end
      for (int i = 0; i < KT[s]; i++) in_vec[i] = (i < got.size()) ? got[i] : 1'b0;
      run_block(s, 1'b1, 1'b0, 1'b1, -1);
      check("rt_back_len", got.size(), KT[s]);
    end

    // K6144 with random stalls on both sides must match the no-stall output
    for (int i = 0; i < 6144; i++) in_vec[i] = save_in[i];
    rand_rdy = 1'b1;
    run_block(2, 1'b0, 1'b1, 1'b0, -1);
    rand_rdy = 1'b0;
    check("stall_len", got.size(), 6144);
    for (int i = 0; i < 6144 && i < got.size(); i++)
      check("stall_vs_nostall", int'(got[i]), int'(ref_out[i]));

    // Reserved ksel: single cfg_err pulse, no block started
    @(posedge clk_i); #1;
    start_i = 1'b1; ksel_i = 2'd3; deint_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cnt_err = 0; cnt_busy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      cnt_err  += int'(cfg_err_o);
      cnt_busy += int'(busy_o);
    end
    check("cfg_err_pulses", cnt_err, 1);
    check("busy_on_reserved", cnt_busy, 0);

    // start/ksel/deint toggled during LOAD must be ignored
    rand_vec(40);
    run_block(0, 1'b0, 1'b0, 1'b0, 10);
    check("ignore_start_len", got.size(), 40);

    // Reset in the middle of UNLOAD, then a fresh K40 block
    rand_vec(1056);
    got.delete();
    push_expect(1, 1'b0, 1'b0);
    do_start(1, 1'b0);
    feed(1056, 1'b0, -1);
    t = 0;
    while (got.size() < 500 && t < 5000) begin @(posedge clk_i); t++; end
    check("reached_500_outputs", int'(got.size() >= 500), 1);
    #2; reset_i = 1'b1; #1;
    check("midrst_in_ready",  int'(in_ready_o),  0);
    check("midrst_out_valid", int'(out_valid_o), 0);
    check("midrst_out_bit",   int'(out_bit_o),   0);
    check("midrst_out_last",  int'(out_last_o),  0);
    check("midrst_busy",      int'(busy_o),      0);
    check("midrst_cfg_err",   int'(cfg_err_o),   0);
    exp_q.delete();
    @(posedge clk_i); #1; reset_i = 1'b0;
    rand_vec(40);
    run_block(0, 1'b0, 1'b0, 1'b0, -1);
    check("post_rst_len", got.size(), 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
